// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub unit and its hex display.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'd0,
    OP_SUB     = 2'd1,
    OP_ACC_ADD = 2'd2,
    OP_ACC_SUB = 2'd3
  } op_e;

  // Segment patterns {g,f,e,d,c,b,a}, active-high; element k is hex digit k
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex7seg
  import addsub_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the active-high segment pattern
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/addsub_seg_unit.sv
// Clocked add/sub unit with accumulator, valid/ready handshakes and a
// scanned hex seven-segment display of the result register.
// Optional: define ADDSUB_SAT_EN to saturate results on signed overflow.
module addsub_seg_unit
  import addsub_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned SCAN_DIV = 1000,
  localparam int unsigned DIGITS   = (WIDTH + 3) / 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PAD_W = DIGITS * 4;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;

  op_e              op_sel;
  logic             is_acc;
  logic             is_sub;
  logic [WIDTH-1:0] x_opnd;
  logic [WIDTH-1:0] y_opnd;
  logic [WIDTH:0]   sum;
  logic             ovf_c;
  logic [WIDTH-1:0] res_c;
  logic             accept;
  logic [PAD_W-1:0] padded;
  logic [3:0]       nibble;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Datapath: operand select, X + (Y or ~Y) + sub, flags, optional clamp
  always_comb begin
    op_sel = op_e'(op);
    is_acc = (op_sel == OP_ACC_ADD) || (op_sel == OP_ACC_SUB);
    is_sub = (op_sel == OP_SUB) || (op_sel == OP_ACC_SUB);
    x_opnd = is_acc ? acc : a;
    y_opnd = is_sub ? ~b : b;
    sum    = {1'b0, x_opnd} + {1'b0, y_opnd} + (WIDTH+1)'(is_sub);
    ovf_c  = (x_opnd[WIDTH-1] == y_opnd[WIDTH-1]) &&
             (sum[WIDTH-1] != x_opnd[WIDTH-1]);
    res_c  = sum[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
    // Both operands share a sign on overflow; that sign picks the rail
    if (ovf_c) begin
      res_c = x_opnd[WIDTH-1] ? SMIN : SMAX;
    end
`endif
  end

  // Result register, flags, accumulator and output-valid tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        result    <= res_c;
        carry     <= sum[WIDTH];
        overflow  <= ovf_c;
        acc       <= res_c;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Scan divider and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Select the current nibble and drive the one-hot digit enable
  always_comb begin
    padded = PAD_W'(result);
    nibble = 4'(padded >> {idx_q, 2'b00});
    an     = DIGITS'(1) << idx_q;
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg)
  );

endmodule

// File: doc/addsub_seg_unit.md
# addsub_seg_unit

Parametrised, clocked adder/subtractor with an accumulator, valid/ready handshakes on input and result, carry and signed-overflow flags, and a time-multiplexed hexadecimal seven-segment driver. It succeeds the 4-bit combinational add/sub-plus-decoder pair. It sits between operand sources (switches or upstream logic) and the board display, and presents every result both on a handshaked output port and on the scanned digits.

## Interface
- WIDTH, 8, operand/result width in bits (≥4)
- SCAN_DIV, 1000, clock cycles each digit is held during display scan (≥1)
- DIGITS (localparam), (WIDTH+3)/4, number of hex digits displayed
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept an operation
- a  in  WIDTH  operand A (ignored by accumulate ops)
- b  in  WIDTH  operand B
- op  in  2  0=ADD (a+b), 1=SUB (a−b), 2=ACC_ADD (acc+b), 3=ACC_SUB (acc−b)
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream consumes result
- result  out  WIDTH  registered result
- carry  out  1  carry-out; for subtraction 1 = no borrow (two's-complement convention)
- overflow  out  1  signed overflow of the operation
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-high
- an  out  DIGITS  one-hot digit enable, active-high; bit k shows nibble k of result

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready (single-entry output register, full throughput).
- Subtraction is X + ~Y + 1 over WIDTH bits; carry is bit WIDTH of that sum. overflow = operands' sign bits (after Y inversion) equal and sum sign differs.
- On accept: result, carry, overflow registered; accumulator acc loaded with the final result value (all four ops).
- out_valid set on accept; cleared on out_ready && out_valid with no simultaneous accept; stays 1 on simultaneous consume+accept (new result replaces).
- in_valid with in_ready low: no effect; source holds.
- Display: divider counts 0..SCAN_DIV−1; on wrap, digit index advances modulo DIGITS (DIGITS−1 wraps to 0). an = one-hot(index). seg = hex pattern of nibble index of result; top nibble zero-extended when WIDTH%4≠0. Display always shows the result register, independent of out_valid.
- Hex patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.

## Timing
- Result latency: 1 cycle (accept at edge n → result/flags/out_valid visible after edge n).
- seg/an combinational from registered index and result: a new result appears on the current digit in the same cycle it appears on result.
- Reset (asynchronous assert, any cycle, mid-scan or mid-handshake): out_valid=0, result=0, carry=0, overflow=0, acc=0, divider=0, index=0 → an=one-hot bit 0, seg=3F, in_ready=1.

## Configuration
- ADDSUB_SAT_EN defined: on signed overflow, result (and acc) clamps to 2^(WIDTH−1)−1 for positive overflow, −2^(WIDTH−1) for negative; overflow flag and carry still reported as computed.
- Undefined: result wraps modulo 2^WIDTH.

## Structure
- Package addsub_pkg: op enum (OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB), 16-entry hex segment constant table.
- Sub-module hex7seg: combinational 4-bit nibble → 7-bit segment pattern, one instance fed by the selected nibble.

## Test plan
- WIDTH=8, ADD a=0x2D b=0x3C → next cycle result=0x69, carry=0, overflow=0, out_valid=1.
- SUB a=0x32 b=0x0A → result=0x28, carry=1; SUB a=0x0A b=0x32 → result=0xD8, carry=0, overflow=0.
- ADD a=0x70 b=0x70 → overflow=1, result=0xE0 (wrap) or 0x7F with ADDSUB_SAT_EN.
- Backpressure: out_ready=0, two ops back-to-back → first accepted, in_ready=0, second held; out_ready=1 → second accepted same cycle, out_valid stays 1.
- Accumulate: ADD 0x05+0x00, then three ACC_ADD b=0x03 → results 0x08, 0x0B, 0x0E; ACC_SUB b=0x0F → 0xFF, carry=0.
- Display with SCAN_DIV=4, result=0x69: an=01 seg=6F for 4 cycles, then an=10 seg=7D, then back to 01; reset asserted mid-scan → an=01, seg=3F immediately.
